// File: rtl/lives_manager.sv
// lives_manager: saturating life counter with post-hit invulnerability window and game-over flag.
// Latency 1 cycle, no combinational input-to-output path; optional heart blink under `LIVES_BLINK_EN`.
module lives_manager #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       frame_tick,
  output logic [1:0] lives,
  output logic       invuln,
  output logic       blink,
  output logic       game_over
);

  localparam int CW = $clog2(INVULN_FRAMES + 1);
  localparam logic [1:0]    START_L = 2'(START_LIVES);
  localparam logic [1:0]    MAX_L   = 2'(MAX_LIVES);
  localparam logic [CW-1:0] INV_L   = CW'(INVULN_FRAMES);

  if (START_LIVES < 1 || START_LIVES > MAX_LIVES || MAX_LIVES > 3 ||
      INVULN_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("lives_manager: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_INVULN, S_OVER} state_t;

  state_t        state, state_nxt;
  logic [1:0]    lives_q, lives_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lives_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      lives_q <= lives_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lives_nxt = lives_q;
    cnt_nxt   = cnt;
    if (new_game) begin
      state_nxt = S_ALIVE;
      lives_nxt = START_L;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_ALIVE: begin
          if (hit && extra_life) begin
            // The granted life cancels the lost one, but the window still opens.
            state_nxt = S_INVULN;
            cnt_nxt   = INV_L;
          end else if (hit) begin
            if (lives_q > 2'd1) begin
              lives_nxt = lives_q - 2'd1;
              state_nxt = S_INVULN;
              cnt_nxt   = INV_L;
            end else begin
              lives_nxt = 2'd0;
              state_nxt = S_OVER;
            end
          end else if (extra_life && lives_q < MAX_L) begin
            lives_nxt = lives_q + 2'd1;
          end
        end
        S_INVULN: begin
          if (extra_life && lives_q < MAX_L) begin
            lives_nxt = lives_q + 2'd1;
          end
          if (frame_tick) begin
            if (cnt <= CW'(1)) begin
              cnt_nxt   = '0;
              state_nxt = S_ALIVE;
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lives     = lives_q;
  assign invuln    = (state == S_INVULN);
  assign game_over = (state == S_OVER);

`ifdef LIVES_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          blink_q, blink_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt    <= bcnt_nxt;
      blink_q <= blink_nxt;
    end
  end

  always_comb begin
    bcnt_nxt  = bcnt;
    blink_nxt = blink_q;
    if (state_nxt != S_INVULN) begin
      bcnt_nxt  = '0;
      blink_nxt = 1'b0;
    end else if (state != S_INVULN) begin
      // Hearts light up on the very edge that opens the window.
      bcnt_nxt  = '0;
      blink_nxt = 1'b1;
    end else if (frame_tick) begin
      if (bcnt == BLINK_LAST) begin
        bcnt_nxt  = '0;
        blink_nxt = ~blink_q;
      end else begin
        bcnt_nxt = bcnt + BW'(1);
      end
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: doc/lives_manager.md
# lives_manager

Owns the player's life count and feeds the 2-bit `lives` value consumed by the heart renderer. Sits between collision detection, game control and the VGA overlay. Converts single-cycle hit, extra-life and new-game pulses into a saturating life count, a post-hit invulnerability window, a blink flag and a sticky game-over flag. All outputs are registered and stable for the whole frame between `frame_tick` pulses, unless an event occurs in that frame.

## Interface

Parameters:
- `START_LIVES`, 3: lives loaded on `new_game`. Legal range is 1..`MAX_LIVES`.
- `MAX_LIVES`, 3: saturation ceiling. Must be ≤3 so it fits the 2-bit bus.
- `INVULN_FRAMES`, 60: length of the invulnerability window after a non-fatal hit, in `frame_tick` pulses. Must be ≥1.
- `BLINK_FRAMES`, 8: `blink` half-period in frames. Used only with `LIVES_BLINK_EN`.

Ports:
- `clk`, in, 1: system clock. Everything is on the rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `new_game`, in, 1: single-cycle pulse that starts a new game.
- `hit`, in, 1: single-cycle pulse when the player is struck.
- `extra_life`, in, 1: single-cycle pulse that grants one life.
- `frame_tick`, in, 1: single-cycle pulse once per frame, at the start of vertical blank.
- `lives`, out, 2: current life count, 0..`MAX_LIVES`.
- `invuln`, out, 1: high while in INVULN.
- `blink`, out, 1: heart-flash flag for the overlay.
- `game_over`, out, 1: sticky, high in OVER.

## Operation

States:
- IDLE is the reset state.
- ALIVE, INVULN and OVER are the play states.

Transitions (`new_game` has top priority in every state):
- **`new_game` in any state:** set `lives`=`START_LIVES`, clear the invulnerability counter and `blink`, clear `game_over`, go to ALIVE. Any `hit` or `extra_life` in the same cycle is ignored.
- **ALIVE, `hit` with `lives`>1:** `lives`−1. Load the counter with `INVULN_FRAMES`. Go to INVULN.
- **ALIVE, `hit` with `lives`==1:** `lives`=0. Go to OVER and set `game_over`=1.
- **INVULN:** `hit` is ignored. Each `frame_tick` decrements the counter. A tick that takes the counter from 1 to 0 moves the state to ALIVE on the same edge.
- **`extra_life` in ALIVE or INVULN:** `lives`+1, saturating at `MAX_LIVES`. It is ignored in IDLE and OVER.
- **`hit` and `extra_life` together in ALIVE:**
  - Net life change is 0 (from 1, `lives` stays 1). At `MAX_LIVES`, `lives` also stays unchanged.
  - The state still moves to INVULN and the counter is loaded. No game over.
- **IDLE and OVER:** only `new_game` has any effect.

Arithmetic:
- Counter width is $clog2(`INVULN_FRAMES`+1).
- `lives` never wraps: it never goes below 0 and never above `MAX_LIVES`.

## Timing

- Every output changes on the first rising edge after the input pulse is sampled high (1-cycle latency). There is no combinational path from inputs to outputs.
- Reset values (async assert, held while `rst_n`=0): state IDLE, `lives`=0, `invuln`=0, `blink`=0, `game_over`=0, counter=0.
- Reset deassertion takes effect on the next clock edge. Reset during INVULN or OVER aborts immediately to IDLE.
- `invuln` lasts exactly `INVULN_FRAMES` `frame_tick` pulses. The first pulse counted is the first one after the cycle that accepted the hit. A `frame_tick` in the same cycle as the hit is not counted.
- Inputs are assumed already synchronous to `clk`. A pulse held high for N cycles is treated as N events; upstream must pulse.

## Configuration

- **`LIVES_BLINK_EN` defined:**
  - In INVULN, `blink` toggles every `BLINK_FRAMES` `frame_tick` pulses, using its own sub-counter.
  - `blink` goes high on the INVULN entry edge.
  - `blink` is forced to 0 when leaving INVULN.
- **`LIVES_BLINK_EN` undefined:** `blink` is tied to 0, and the blink sub-counter and its logic are not synthesized.
- All other behaviour is identical in both builds.

## Test plan

1. Reset, then `new_game` pulse → `lives`=3, state ALIVE, `game_over`=0 one cycle later.
2. Three `hit` pulses, each separated by 61 `frame_tick` pulses → `lives` goes 2, 1, 0. `invuln` is high for exactly 60 ticks after hits 1 and 2. `game_over`=1 after hit 3.
3. `hit`, then a second `hit` 5 frames later → `lives` stays 2 (second hit ignored), `invuln` still high.
4. `extra_life` at `lives`=3 → stays 3. `hit` and `extra_life` in the same cycle at `lives`=1 → `lives`=1, `invuln`=1, `game_over`=0.
5. `rst_n` pulled low mid-INVULN (counter=30) → all outputs 0 asynchronously, state IDLE. A subsequent `hit` changes nothing.
6. With `LIVES_BLINK_EN`, `hit` → `blink`=1, toggles at ticks 8, 16, …, and is 0 when `invuln` falls. Without the macro, `blink` stays 0 throughout.
